display_scan: RTL

Multiplexed seven-segment scanner that sits directly downstream of the ripple frequency divider. It takes one divider tap as its scan rate, synchronises and edge-detects it into a single-cycle tick, and drives one digit per tick through active-low anode and segment lines. New digit values are double-buffered and applied only at frame boundaries, so a digit never changes mid-frame.

---
 rtl/display_scan_if.sv | 30 +++
 rtl/display_scan.sv | 126 ++++++++++++
 2 files changed

// File: rtl/display_scan_if.sv
// Display-side bus of the seven-segment scanner: digit data and load
// handshake in, active-low anode/segment lines and status pulses out.
interface display_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits_in;
    logic                load;
    logic                load_ack;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                frame;

    modport master (
        output digits_in,
        output load,
        input  load_ack,
        input  an,
        input  seg,
        input  frame
    );

    modport slave (
        input  digits_in,
        input  load,
        output load_ack,
        output an,
        output seg,
        output frame
    );
endinterface

// File: rtl/display_scan.sv
// Multiplexed seven-segment scanner driven by a divider tap.
// The tap is synchronised and edge-detected into a one-cycle tick; each tick
// lights the next digit. Digit data is double-buffered and swapped in only
// when the scan wraps to digit 0, so a frame never mixes old and new values.
// Build option: define DISPLAY_SCAN_HEX_EN to show 10..15 as A,b,C,d,E,F;
// otherwise those values are blanked.
module display_scan #(
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick_src,
    display_scan_if.slave  bus
);

    localparam int              IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    logic                s1, s2, s3;
    logic                tick;
    logic                wrap;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic                en;
    logic                en_next;
    logic                pending;
    logic [4*DIGITS-1:0] active;
    logic [4*DIGITS-1:0] staged;
    logic [4*DIGITS-1:0] active_next;
    logic [3:0]          digit_next;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one digit value.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
`ifdef DISPLAY_SCAN_HEX_EN
            4'd10:   s = 7'h08;
            4'd11:   s = 7'h03;
            4'd12:   s = 7'h46;
            4'd13:   s = 7'h21;
            4'd14:   s = 7'h06;
            4'd15:   s = 7'h0E;
`endif
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Three-flop synchroniser for the asynchronous divider tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_src;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick     = s2 & ~s3;
    assign wrap     = tick & (idx == LAST);
    assign idx_next = (idx == LAST) ? '0 : idx + IDX_W'(1);
    assign en_next  = en | tick;

    // Data that will be active after this cycle; at a wrap a same-cycle load
    // bypasses the staging buffer so the digit shown at the wrap is already new.
    always_comb begin
        active_next = active;
        if (wrap) begin
            if (bus.load) begin
                active_next = bus.digits_in;
            end else if (pending) begin
                active_next = staged;
            end
        end
    end

    assign digit_next = active_next[{idx_next, 2'b00} +: 4];

    // Scan position, buffer swap and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= LAST;
            en           <= 1'b0;
            pending      <= 1'b0;
            active       <= '0;
            staged       <= '0;
            bus.an       <= '1;
            bus.seg      <= 7'h7F;
            bus.frame    <= 1'b0;
            bus.load_ack <= 1'b0;
        end else begin
            bus.load_ack <= 1'b0;
            bus.frame    <= wrap;
            if (tick) begin
                en      <= 1'b1;
                idx     <= idx_next;
                bus.an  <= en_next ? ~(DIGITS'(1) << idx_next) : '1;
                bus.seg <= decode(digit_next);
            end
            if (wrap) begin
                if (bus.load || pending) begin
                    active       <= active_next;
                    pending      <= 1'b0;
                    bus.load_ack <= 1'b1;
                end
            end else if (bus.load) begin
                staged  <= bus.digits_in;
                pending <= 1'b1;
            end
        end
    end

endmodule
